uart_frame_loader: RTL and testbench

UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

---
 rtl/uart_frame_loader_if.sv | 26 ++
 rtl/uart_frame_loader.sv | 124 ++++++++++++
 tb/tb_uart_frame_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_loader_if.sv
// rtl/uart_frame_loader_if.sv - received-byte stream in, RAM write port out
interface uart_frame_loader_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata;

   modport master (
      output rx_data,
      output rx_valid,
      input  ram_we,
      input  ram_addr,
      input  ram_wdata
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output ram_we,
      output ram_addr,
      output ram_wdata
   );
endinterface

// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - parses SYNC/ADDR/LEN/DATA/CSUM frames into RAM writes
module uart_frame_loader #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 1200000
) (
   input  logic                CLK,
   input  logic                reset_n,
   uart_frame_loader_if.slave  bus,
   output logic                frame_done,
   output logic                frame_err,
   output logic [7:0]          err_count,
   output logic [7:0]          leds
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [7:0] SYNC = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      GET_LEN,
      GET_DATA,
      GET_CSUM
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [7:0]        rem_q;
   logic [7:0]        sum_q;
   logic [CNT_W-1:0]  tmo_q;
   logic              ram_we_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [7:0]        ram_wdata_q;
   logic              done_q;
   logic              err_q;
   logic [7:0]        err_cnt_q;
   logic [7:0]        leds_q;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         rem_q       <= '0;
         sum_q       <= '0;
         tmo_q       <= '0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
         leds_q      <= '0;
      end else begin
         ram_we_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;

         if (err_q && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;

         // An arriving byte always beats an expiring inter-byte timer
         if (state_q == IDLE || bus.rx_valid) begin
            tmo_q <= '0;
         end else if (tmo_q == TMO_LAST) begin
            tmo_q   <= '0;
            err_q   <= 1'b1;
            state_q <= IDLE;
         end else begin
            tmo_q <= tmo_q + CNT_W'(1);
         end

         if (bus.rx_valid) begin
            case (state_q)
               IDLE: begin
                  if (bus.rx_data == SYNC)
                     state_q <= GET_ADDR;
               end
               GET_ADDR: begin
                  ptr_q   <= ADDR_W'(bus.rx_data);
                  sum_q   <= bus.rx_data;
                  state_q <= GET_LEN;
               end
               GET_LEN: begin
                  if (bus.rx_data == 8'h00) begin
                     err_q   <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     rem_q   <= bus.rx_data;
                     sum_q   <= sum_q + bus.rx_data;
                     state_q <= GET_DATA;
                  end
               end
               GET_DATA: begin
                  ram_we_q    <= 1'b1;
                  ram_addr_q  <= ptr_q;
                  ram_wdata_q <= bus.rx_data;
                  leds_q      <= bus.rx_data;
                  ptr_q       <= ptr_q + ADDR_W'(1);
                  rem_q       <= rem_q - 8'd1;
                  sum_q       <= sum_q + bus.rx_data;
                  if (rem_q == 8'd1)
                     state_q <= GET_CSUM;
               end
               GET_CSUM: begin
                  if (bus.rx_data == sum_q)
                     done_q <= 1'b1;
                  else
                     err_q <= 1'b1;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.ram_we    = ram_we_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign frame_done    = done_q;
   assign frame_err     = err_q;
   assign err_count     = err_cnt_q;
   assign leds          = leds_q;
endmodule

// File: tb/tb_uart_frame_loader.sv
// tb/tb_uart_frame_loader.sv - directed frame vectors against hand-computed RAM writes
module tb_uart_frame_loader;
   localparam int ADDR_W = 8;
   localparam int TMO    = 20;

   logic       CLK = 1'b0;
   logic       reset_n = 1'b0;
   logic       frame_done;
   logic       frame_err;
   logic [7:0] err_count;
   logic [7:0] leds;

   uart_frame_loader_if #(.ADDR_W(ADDR_W)) bus ();

   uart_frame_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
      .CLK        (CLK),
      .reset_n    (reset_n),
      .bus        (bus),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .err_count  (err_count),
      .leds       (leds)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   int done_n  = 0;
   int err_n   = 0;
   int both_n  = 0;
   logic [15:0] wr_q[$];

   always @(negedge CLK) begin
      if (bus.ram_we) wr_q.push_back({bus.ram_addr, bus.ram_wdata});
      if (frame_done) done_n++;
      if (frame_err) err_n++;
      if (frame_done && frame_err) both_n++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      wr_q.delete();
      done_n = 0;
      err_n  = 0;
      both_n = 0;
   endtask

   task automatic send(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge CLK);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_seq(input logic [7:0] s[$]);
      foreach (s[i]) send(s[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      @(posedge CLK);
      #1;
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
      idle(1);
      clear_log();
   endtask

   initial begin
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      idle(2);
      reset_n = 1'b1;
      idle(1);
      check("rst_we", bus.ram_we, 0);
      check("rst_addr", bus.ram_addr, 0);
      check("rst_wdata", bus.ram_wdata, 0);
      check("rst_done_err", {frame_done, frame_err}, 0);
      check("rst_errcnt", err_count, 0);
      check("rst_leds", leds, 0);
      clear_log();

      // 0x10+0x03+0x11+0x22+0x33 = 0x79
      send_seq('{8'hA5, 8'h10, 8'h03});
      send(8'h11);
      check("lat_we", bus.ram_we, 1);
      check("lat_addr_data", {bus.ram_addr, bus.ram_wdata}, 16'h1011);
      send_seq('{8'h22, 8'h33, 8'h79});
      idle(3);
      check("f1_nwr", wr_q.size(), 3);
      check("f1_wr0", wr_q[0], 16'h1011);
      check("f1_wr1", wr_q[1], 16'h1122);
      check("f1_wr2", wr_q[2], 16'h1233);
      check("f1_done", done_n, 1);
      check("f1_err", err_n, 0);
      check("f1_leds", leds, 8'h33);
      check("f1_errcnt", err_count, 0);

      do_reset();
      send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00});
      idle(3);
      check("f2_nwr", wr_q.size(), 3);
      check("f2_wr2", wr_q[2], 16'h1233);
      check("f2_done", done_n, 0);
      check("f2_err", err_n, 1);
      check("f2_errcnt", err_count, 1);

      clear_log();
      send_seq('{8'hA5, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'h07});
      idle(3);
      check("wrap_nwr", wr_q.size(), 3);
      check("wrap_wr0", wr_q[0], 16'hFE01);
      check("wrap_wr1", wr_q[1], 16'hFF02);
      check("wrap_wr2", wr_q[2], 16'h0003);
      check("wrap_done", done_n, 1);

      do_reset();
      send_seq('{8'h55, 8'hA5, 8'h20, 8'h00});
      idle(3);
      check("len0_nwr", wr_q.size(), 0);
      check("len0_err", err_n, 1);
      check("len0_errcnt", err_count, 1);

      do_reset();
      send_seq('{8'hA5, 8'h40, 8'h02, 8'hAA});
      idle(TMO - 1);
      check("tmo_early", err_n, 0);
      idle(1);
      check("tmo_err", frame_err, 1);
      idle(2);
      check("tmo_nwr", wr_q.size(), 1);
      check("tmo_wr0", wr_q[0], 16'h40AA);
      clear_log();
      send_seq('{8'hA5, 8'h00, 8'h01, 8'h5A, 8'h5B});
      idle(3);
      check("tmo_next_done", done_n, 1);
      check("tmo_next_err", err_n, 0);

      // byte lands on the expiry cycle: 0x40+0x02+0xAA+0xBB = 0xA7
      clear_log();
      send_seq('{8'hA5, 8'h40, 8'h02, 8'hAA});
      idle(TMO - 1);
      send(8'hBB);
      send(8'hA7);
      idle(3);
      check("race_err", err_n, 0);
      check("race_done", done_n, 1);
      check("race_wr1", wr_q[1], 16'h41BB);

      clear_log();
      send_seq('{8'hA5, 8'h40, 8'h02, 8'hAA});
      reset_n = 1'b0;
      #1;
      check("arst_we", bus.ram_we, 0);
      check("arst_outs", {bus.ram_addr, bus.ram_wdata, leds, err_count}, 0);
      idle(2);
      reset_n = 1'b1;
      idle(1);
      check("arst_err", err_n, 0);
      clear_log();
      send_seq('{8'hA5, 8'h00, 8'h01, 8'h5A, 8'h5B});
      idle(3);
      check("arst_nwr", wr_q.size(), 1);
      check("arst_wr0", wr_q[0], 16'h005A);
      check("arst_done", done_n, 1);

      for (int i = 0; i < 260; i++) send_seq('{8'hA5, 8'h00, 8'h00});
      idle(3);
      check("sat_errcnt", err_count, 8'hFF);
      check("never_both", both_n, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
